// File: rtl/if_fetch_queue.sv
// if_fetch_queue: instruction fetch stage. Owns the fetch PC, issues one word
// read per cycle to instruction memory, and buffers returned {pc, instr}
// pairs in a small FIFO that feeds the IF/ID register. Decode stalls
// back-pressure the fetch; branch redirects and reset flush everything in flight.
module if_fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic                         CLK,
  input  logic                         reset,
  input  logic [63:0]                  startpc,
  output logic                         imem_req,
  output logic [63:0]                  imem_addr,
  input  logic [31:0]                  imem_rdata,
  input  logic                         redirect,
  input  logic [63:0]                  redirect_pc,
  input  logic                         id_stall,
  output logic                         if_valid,
  output logic [31:0]                  if_instr,
  output logic [63:0]                  if_pc,
  output logic [63:0]                  currentpc,
  output logic [$clog2(DEPTH+1)-1:0]   queue_count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } entry_t;

  logic [63:0]   fetch_pc_q, fetch_pc_d;
  logic [63:0]   issued_pc_q, issued_pc_d;
  logic          inflight_q, inflight_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  entry_t        fifo_mem [DEPTH];

  logic          flush;
  logic          issue;
  logic          push;
  logic          pop;
  logic [CW-1:0] occupancy;
  entry_t        head;

  // Entries already queued plus the one word still on its way back; a new
  // request is only allowed when that word is guaranteed a free slot.
  assign flush     = reset || redirect;
  assign occupancy = count_q + CW'(inflight_q);
  assign issue     = !flush && (occupancy < DEPTH_C);
  assign push      = inflight_q && !flush;
  assign pop       = if_valid && !id_stall;

  // Next-state for fetch PC, in-flight tracking and FIFO pointers/count.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    fetch_pc_d  = fetch_pc_q;
    issued_pc_d = issued_pc_q;
    inflight_d  = 1'b0;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;

    if (redirect) begin
      fetch_pc_d = redirect_pc;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (issue) begin
        issued_pc_d = fetch_pc_q;
        fetch_pc_d  = fetch_pc_q + 64'd4;
        inflight_d  = 1'b1;
      end
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state with synchronous reset that reloads the fetch PC.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      fetch_pc_q <= startpc;
      inflight_q <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Datapath: issued PC capture and FIFO storage writes.
  always_ff @(posedge CLK) begin
    // NOTE: the payload registers are deliberately not reset; validity is
    // carried entirely by inflight_q and count_q, so stale contents are never
    // observed.
    issued_pc_q <= issued_pc_d;
    if (push) fifo_mem[wr_ptr_q] <= '{pc: issued_pc_q, instr: imem_rdata};
  end

  assign head        = fifo_mem[rd_ptr_q];
  assign if_valid    = (count_q != '0);
  assign if_instr    = if_valid ? head.instr : 32'd0;
  assign if_pc       = if_valid ? head.pc : 64'd0;
  assign imem_req    = issue;
  assign imem_addr   = fetch_pc_q;
  assign currentpc   = fetch_pc_q;
  assign queue_count = count_q;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Testbench for if_fetch_queue: constant-expectation vector table, directed
// corner sequences, and a randomized run compared every cycle against a
// queue-based reference model of the fetch stage.
module tb_if_fetch_queue;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          CLK = 1'b0;
  logic          reset = 1'b1;
  logic [63:0]   startpc = 64'h0;
  logic          imem_req;
  logic [63:0]   imem_addr;
  logic [31:0]   imem_rdata = 32'h0;
  logic          redirect = 1'b0;
  logic [63:0]   redirect_pc = 64'h0;
  logic          id_stall = 1'b0;
  logic          if_valid;
  logic [31:0]   if_instr;
  logic [63:0]   if_pc;
  logic [63:0]   currentpc;
  logic [CW-1:0] queue_count;

  always #5 CLK = ~CLK;

  if_fetch_queue #(.DEPTH(DEPTH)) dut (
    .CLK         (CLK),
    .reset       (reset),
    .startpc     (startpc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .id_stall    (id_stall),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .currentpc   (currentpc),
    .queue_count (queue_count)
  );

  function automatic logic [31:0] word_at(input logic [63:0] a);
    return 32'hAA00_0000 + {20'd0, a[11:0]};
  endfunction

  // Instruction memory: word returns one cycle after the request cycle.
  always @(posedge CLK) imem_rdata <= imem_req ? word_at(imem_addr) : 32'h0BAD_0BAD;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: fetch PC, one outstanding request, queue of entries.
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        mq[$];
  logic [63:0] m_pc = 64'h0;
  logic [63:0] m_issued = 64'h0;
  bit          m_inflight = 1'b0;
  bit          m_known = 1'b0;
  bit          m_req = 1'b0;

  task automatic apply(input bit rst, input bit rd, input logic [63:0] rpc, input bit stall);
    reset = rst; redirect = rd; redirect_pc = rpc; id_stall = stall;
    #1;
    if (m_known) begin
      m_req = !rst && !rd && ((mq.size() + int'(m_inflight)) < DEPTH);
      check("model_req", 64'(imem_req), 64'(m_req));
      check("model_addr", imem_addr, m_pc);
      check("model_currentpc", currentpc, m_pc);
      check("model_count", 64'(queue_count), 64'(mq.size()));
      check("model_valid", 64'(if_valid), 64'(mq.size() > 0));
      check("model_pc", if_pc, (mq.size() > 0) ? mq[0].pc : 64'h0);
      check("model_instr", 64'(if_instr), (mq.size() > 0) ? 64'(mq[0].instr) : 64'h0);
    end
  endtask

  task automatic advance();
    @(posedge CLK);
    if (reset) begin
      mq.delete();
      m_pc = startpc; m_inflight = 1'b0; m_known = 1'b1;
    end else if (m_known && redirect) begin
      mq.delete();
      m_pc = redirect_pc; m_inflight = 1'b0;
    end else if (m_known) begin
      if (mq.size() > 0 && !id_stall) void'(mq.pop_front());
      if (m_inflight) mq.push_back(ent_t'{pc: m_issued, instr: word_at(m_issued)});
      if (m_req) begin
        m_issued = m_pc; m_pc = m_pc + 64'd4; m_inflight = 1'b1;
      end else begin
        m_inflight = 1'b0;
      end
    end
    #1;
  endtask

  task automatic step(input bit stall);
    apply(1'b0, 1'b0, 64'h0, stall);
    advance();
  endtask

  // Two reset cycles; the second checks the reset output values.
  task automatic do_reset(input logic [63:0] spc);
    startpc = spc;
    apply(1'b1, 1'b0, 64'h0, 1'b0);
    advance();
    apply(1'b1, 1'b0, 64'h0, 1'b0);
    check("rst_req", 64'(imem_req), 64'h0);
    check("rst_valid", 64'(if_valid), 64'h0);
    check("rst_instr", 64'(if_instr), 64'h0);
    check("rst_pc", if_pc, 64'h0);
    check("rst_count", 64'(queue_count), 64'h0);
    check("rst_currentpc", currentpc, spc);
    advance();
  endtask

  typedef struct {
    bit          stall;
    bit          exp_req;
    logic [63:0] exp_addr;
    bit          exp_valid;
    logic [63:0] exp_pc;
    logic [31:0] exp_instr;
    int          exp_count;
  } vec_t;

  vec_t tbl[8];
  int   stall_pct;

  initial begin
    tbl[0] = '{stall:0, exp_req:1, exp_addr:64'h1000, exp_valid:0, exp_pc:64'h0,    exp_instr:32'h0,         exp_count:0};
    tbl[1] = '{stall:0, exp_req:1, exp_addr:64'h1004, exp_valid:0, exp_pc:64'h0,    exp_instr:32'h0,         exp_count:0};
    tbl[2] = '{stall:0, exp_req:1, exp_addr:64'h1008, exp_valid:1, exp_pc:64'h1000, exp_instr:32'hAA00_0000, exp_count:1};
    tbl[3] = '{stall:0, exp_req:1, exp_addr:64'h100C, exp_valid:1, exp_pc:64'h1004, exp_instr:32'hAA00_0004, exp_count:1};
    tbl[4] = '{stall:0, exp_req:1, exp_addr:64'h1010, exp_valid:1, exp_pc:64'h1008, exp_instr:32'hAA00_0008, exp_count:1};
    tbl[5] = '{stall:0, exp_req:1, exp_addr:64'h1014, exp_valid:1, exp_pc:64'h100C, exp_instr:32'hAA00_000C, exp_count:1};
    tbl[6] = '{stall:1, exp_req:1, exp_addr:64'h1018, exp_valid:1, exp_pc:64'h1010, exp_instr:32'hAA00_0010, exp_count:1};
    tbl[7] = '{stall:0, exp_req:1, exp_addr:64'h101C, exp_valid:1, exp_pc:64'h1010, exp_instr:32'hAA00_0010, exp_count:2};

    // Basic streaming fetch from 0x1000.
    do_reset(64'h1000);
    for (int i = 0; i < 8; i++) begin
      apply(1'b0, 1'b0, 64'h0, tbl[i].stall);
      check("tbl_req", 64'(imem_req), 64'(tbl[i].exp_req));
      check("tbl_addr", imem_addr, tbl[i].exp_addr);
      check("tbl_valid", 64'(if_valid), 64'(tbl[i].exp_valid));
      check("tbl_pc", if_pc, tbl[i].exp_pc);
      check("tbl_instr", 64'(if_instr), 64'(tbl[i].exp_instr));
      check("tbl_count", 64'(queue_count), 64'(tbl[i].exp_count));
      advance();
    end

    // Continuous stall fills the FIFO; release pops in order and re-requests.
    do_reset(64'h1000);
    step(1'b0); step(1'b0);
    step(1'b1); step(1'b1); step(1'b1);
    apply(1'b0, 1'b0, 64'h0, 1'b1);
    check("stall_count_full", 64'(queue_count), 64'd4);
    check("stall_req_low", 64'(imem_req), 64'h0);
    check("stall_currentpc", currentpc, 64'h1010);
    advance();
    for (int k = 0; k < 4; k++) begin
      apply(1'b0, 1'b0, 64'h0, 1'b0);
      check("release_head_pc", if_pc, 64'h1000 + 64'(4 * k));
      if (k == 0) check("release_req_same_cycle", 64'(imem_req), 64'h0);
      if (k == 1) begin
        check("release_req_next_cycle", 64'(imem_req), 64'h1);
        check("release_addr", imem_addr, 64'h1010);
      end
      advance();
    end

    // Redirect with 3 queued entries and one word in flight.
    do_reset(64'h1000);
    step(1'b0); step(1'b0);
    step(1'b1); step(1'b1);
    apply(1'b0, 1'b1, 64'h2000, 1'b1);
    check("redir_pre_count", 64'(queue_count), 64'd3);
    check("redir_req_low", 64'(imem_req), 64'h0);
    advance();
    apply(1'b0, 1'b0, 64'h0, 1'b0);
    check("redir_count", 64'(queue_count), 64'h0);
    check("redir_valid", 64'(if_valid), 64'h0);
    check("redir_req", 64'(imem_req), 64'h1);
    check("redir_addr", imem_addr, 64'h2000);
    advance();
    apply(1'b0, 1'b0, 64'h0, 1'b0);
    check("redir_valid_n2", 64'(if_valid), 64'h0);
    advance();
    apply(1'b0, 1'b0, 64'h0, 1'b0);
    check("redir_head_pc", if_pc, 64'h2000);
    check("redir_head_instr", 64'(if_instr), 64'hAA00_0000);
    advance();
    for (int k = 0; k < 2; k++) begin
      apply(1'b0, 1'b0, 64'h0, 1'b0);
      check("redir_discarded_absent", 64'(if_instr != 32'hAA00_000C), 64'h1);
      advance();
    end

    // Redirect and stall together with the FIFO full: redirect wins.
    do_reset(64'h1000);
    step(1'b0); step(1'b0);
    step(1'b1); step(1'b1); step(1'b1);
    apply(1'b0, 1'b1, 64'h3000, 1'b1);
    check("redir_full_pre_count", 64'(queue_count), 64'd4);
    advance();
    apply(1'b0, 1'b0, 64'h0, 1'b0);
    check("redir_full_count", 64'(queue_count), 64'h0);
    check("redir_full_valid", 64'(if_valid), 64'h0);
    advance();
    step(1'b0);
    apply(1'b0, 1'b0, 64'h0, 1'b0);
    check("redir_full_first_pc", if_pc, 64'h3000);
    advance();

    // Fetch PC wraps modulo 2^64.
    do_reset(64'hFFFF_FFFF_FFFF_FFF8);
    for (int k = 0; k < 6; k++) begin
      apply(1'b0, 1'b0, 64'h0, 1'b0);
      if (k < 4) check("wrap_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFF8 + 64'(4 * k));
      if (k >= 2) check("wrap_head_pc", if_pc, 64'hFFFF_FFFF_FFFF_FFF8 + 64'(4 * (k - 2)));
      advance();
    end

    // Reset mid-stream with two entries queued; restart at the new startpc.
    do_reset(64'h1000);
    step(1'b0); step(1'b0); step(1'b1);
    startpc = 64'h5000;
    apply(1'b1, 1'b0, 64'h0, 1'b1);
    check("midrst_pre_count", 64'(queue_count), 64'd2);
    advance();
    apply(1'b0, 1'b0, 64'h0, 1'b0);
    check("midrst_count", 64'(queue_count), 64'h0);
    check("midrst_valid", 64'(if_valid), 64'h0);
    check("midrst_addr", imem_addr, 64'h5000);
    check("midrst_req", 64'(imem_req), 64'h1);
    advance();
    step(1'b0);
    apply(1'b0, 1'b0, 64'h0, 1'b0);
    check("midrst_head_pc", if_pc, 64'h5000);
    advance();

    // Randomized traffic against the reference model.
    stall_pct = 50;
    for (int c = 0; c < 3000; c++) begin
      bit          rst, rd, st;
      logic [63:0] rpc;
      if (c % 100 == 0) stall_pct = int'($urandom_range(0, 90));
      rst = ($urandom_range(0, 99) < 2);
      rd  = ($urandom_range(0, 99) < 5);
      st  = ($urandom_range(0, 99) < stall_pct);
      rpc = {$urandom(), $urandom()} & ~64'h3;
      if ($urandom_range(0, 9) == 0) rpc = 64'hFFFF_FFFF_FFFF_FFF4;
      if (rst) startpc = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFF0
                                                     : ({$urandom(), $urandom()} & ~64'h3);
      apply(rst, rd, rpc, st);
      advance();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
